// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered grant index/valid for the 2:4 decoder.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       rel,
  output logic [1:0] a,
  output logic       en,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic       any_req;
  logic       normal_rel;
  logic       force_rel;
  logic       release_now;

  if (HOLD_MAX == 0 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arbiter4: HOLD_MAX must be in 1..255");
  end

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    winner  = ptr;
    any_req = |req;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        winner = ptr + 2'(i);
      end
    end
  end

  always_comb begin
    normal_rel  = rel | ~req[a];
    release_now = normal_rel | force_rel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= 2'b00;
      en    <= 1'b0;
      ptr   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            a     <= winner;
            en    <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            en    <= 1'b0;
            ptr   <= a + 2'b01;
            state <= IDLE;
          end
        end
        default: begin
          en    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_cnt;

  always_comb begin
    force_rel = (state == GRANT) && (hold_cnt == HOLD_LAST);
  end

  // The counter sits at zero throughout IDLE, so every grant starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= force_rel & ~normal_rel;
      if (state == GRANT) begin
        hold_cnt <= hold_cnt + 8'd1;
      end else begin
        hold_cnt <= 8'd0;
      end
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4; inputs change 1 time unit after each rising edge.
// Timeout checks use HOLD_MAX=4 when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rel;
  logic [1:0] a;
  logic       en;
  logic       timeout;

  int cmpCount = 0;
  int errCount = 0;

`ifdef ARB_TIMEOUT_EN
  rr_arbiter4 #(.HOLD_MAX(4)) dut (
`else
  rr_arbiter4 dut (
`endif
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .rel     (rel),
    .a       (a),
    .en      (en),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    cmpCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs, let one rising edge sample them, then leave the bench 1 unit after that edge.
  task automatic applyStimulus(input logic [3:0] reqVal, input logic relVal);
    req = reqVal;
    rel = relVal;
    step();
  endtask

  // Starting in an en=0 cycle: expect a grant to expIdx, hold it two cycles, release with rel.
  task automatic grantAndRelease(input string tag, input logic [3:0] reqVal, input logic [1:0] expIdx);
    checkOutput({tag, "_gap_en"}, {7'd0, en}, 8'd0);
    applyStimulus(reqVal, 1'b0);
    checkOutput({tag, "_en"}, {7'd0, en}, 8'd1);
    checkOutput({tag, "_a"}, {6'd0, a}, {6'd0, expIdx});
    applyStimulus(reqVal, 1'b0);
    checkOutput({tag, "_hold_a"}, {6'd0, a}, {6'd0, expIdx});
    applyStimulus(reqVal, 1'b1);
    rel = 1'b0;
    checkOutput({tag, "_rel_en"}, {7'd0, en}, 8'd0);
    checkOutput({tag, "_rel_a"}, {6'd0, a}, {6'd0, expIdx});
  endtask

  initial begin
    logic [1:0] rotSeq [5];
    rotSeq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n = 1'b0;
    req   = 4'b1111;
    rel   = 1'b0;
    step();
    step();
    checkOutput("reset_a", {6'd0, a}, 8'd0);
    checkOutput("reset_en", {7'd0, en}, 8'd0);
    checkOutput("reset_timeout", {7'd0, timeout}, 8'd0);

    // First grant after reset goes to requester 0; then reset asynchronously mid-grant.
    rst_n = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    checkOutput("first_grant_en", {7'd0, en}, 8'd1);
    checkOutput("first_grant_a", {6'd0, a}, 8'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_en", {7'd0, en}, 8'd0);
    req = 4'b0000;
    step();
    rst_n = 1'b1;
    step();
    step();
    checkOutput("idle_no_req_en", {7'd0, en}, 8'd0);

    // Single request from requester 2, then the pointer moves to 3.
    grantAndRelease("single2", 4'b0100, 2'd2);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("idle_hold_a", {6'd0, a}, 8'd2);
    checkOutput("idle_hold_en", {7'd0, en}, 8'd0);
    grantAndRelease("after2", 4'b1111, 2'd3);

    // Rotation with all four requesting.
    for (int i = 0; i < 5; i++) begin
      grantAndRelease($sformatf("rot%0d", i), 4'b1111, rotSeq[i]);
    end

    // Wrap and skip: ptr is 1 here.
    grantAndRelease("wrap3", 4'b1000, 2'd3);
    grantAndRelease("wrap0", 4'b1001, 2'd0);
    grantAndRelease("skip3", 4'b1001, 2'd3);
    grantAndRelease("only1", 4'b0010, 2'd1);

    // Owner drops its request without rel.
    applyStimulus(4'b0010, 1'b0);
    checkOutput("drop_grant_a", {6'd0, a}, 8'd1);
    checkOutput("drop_grant_en", {7'd0, en}, 8'd1);
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("drop_release_en", {7'd0, en}, 8'd0);

    // rel and req drop together count as one release; ptr must land on 2.
    applyStimulus(4'b0010, 1'b0);
    checkOutput("both_grant_a", {6'd0, a}, 8'd1);
    applyStimulus(4'b0000, 1'b1);
    rel = 1'b0;
    checkOutput("both_release_en", {7'd0, en}, 8'd0);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("both_next_a", {6'd0, a}, 8'd2);
    checkOutput("both_next_en", {7'd0, en}, 8'd1);

    // Other request lines toggling during a grant are ignored.
    applyStimulus(4'b0111, 1'b0);
    checkOutput("other_req1_a", {6'd0, a}, 8'd2);
    checkOutput("other_req1_en", {7'd0, en}, 8'd1);
    applyStimulus(4'b1100, 1'b0);
    checkOutput("other_req2_a", {6'd0, a}, 8'd2);
    checkOutput("other_req2_en", {7'd0, en}, 8'd1);
    applyStimulus(4'b0000, 1'b1);
    rel = 1'b0;
    checkOutput("other_rel_en", {7'd0, en}, 8'd0);

    // rel in IDLE is ignored: ptr stays 3, no spurious state change.
    applyStimulus(4'b0000, 1'b1);
    rel = 1'b0;
    checkOutput("idle_rel_en", {7'd0, en}, 8'd0);
    grantAndRelease("idle_rel_next", 4'b1011, 2'd3);

    // Requester 0 holds without releasing; ptr is 0 here.
    applyStimulus(4'b0001, 1'b0);
    checkOutput("hold_c1_en", {7'd0, en}, 8'd1);
    checkOutput("hold_c1_a", {6'd0, a}, 8'd0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      applyStimulus(4'b0001, 1'b0);
      checkOutput($sformatf("hold_c%0d_en", c), {7'd0, en}, 8'd1);
      checkOutput($sformatf("hold_c%0d_to", c), {7'd0, timeout}, 8'd0);
    end
    applyStimulus(4'b0001, 1'b0);
    checkOutput("forced_en", {7'd0, en}, 8'd0);
    checkOutput("forced_timeout", {7'd0, timeout}, 8'd1);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("regrant_en", {7'd0, en}, 8'd1);
    checkOutput("regrant_a", {6'd0, a}, 8'd0);
    checkOutput("regrant_timeout", {7'd0, timeout}, 8'd0);
    // Normal release on the same edge the limit is reached: no timeout pulse.
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("limit_c4_en", {7'd0, en}, 8'd1);
    applyStimulus(4'b0001, 1'b1);
    rel = 1'b0;
    checkOutput("limit_rel_en", {7'd0, en}, 8'd0);
    checkOutput("limit_rel_timeout", {7'd0, timeout}, 8'd0);
`else
    for (int c = 2; c <= 40; c++) begin
      applyStimulus(4'b0001, 1'b0);
      checkOutput($sformatf("hold_c%0d_en", c), {7'd0, en}, 8'd1);
      checkOutput($sformatf("hold_c%0d_to", c), {7'd0, timeout}, 8'd0);
    end
    applyStimulus(4'b0001, 1'b1);
    rel = 1'b0;
    checkOutput("hold_rel_en", {7'd0, en}, 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
